// File: rtl/common.sv
// Project-wide constants shared by the MCU blocks.
package common;
  localparam int ADDR_WIDTH = 16;
endpackage

// File: rtl/img_sender_pkg.sv
// Types and constants for the image sender and the matching receive path in mcu.
package img_sender_pkg;
  import common::*;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    META = 3'd2,
    PRD  = 3'd3,
    PTX  = 3'd4,
    DRD  = 3'd5,
    DTX  = 3'd6,
    FIN  = 3'd7
  } img_send_state_t;

  localparam logic [7:0] IMG_MAGIC0 = 8'h55;
  localparam logic [7:0] IMG_MAGIC1 = 8'hAA;

  localparam logic [ADDR_WIDTH-1:0] DMEM_GVAR_START = ADDR_WIDTH'(16'h0100);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO       = ADDR_WIDTH'(2'd0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE        = ADDR_WIDTH'(2'd1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TWO        = ADDR_WIDTH'(2'd2);

  // Index of the final byte each transmitting state emits.
  function automatic logic [1:0] last_byte_idx(input img_send_state_t st);
    logic [1:0] idx;
    case (st)
      HDR:     idx = 2'd1;
      META:    idx = 2'd3;
      PTX:     idx = 2'd2;
      DTX:     idx = 2'd1;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction
endpackage

// File: rtl/img_sender_if.sv
// Memory-port, control and UART TX byte bundle between img_sender and the MCU.
interface img_sender_if;
  import common::*;

  logic                  start;
  logic [ADDR_WIDTH-1:0] pmem_size;
  logic [ADDR_WIDTH-1:0] dmem_size;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] pmem_addr;
  logic [17:0]           pmem_rdata;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [15:0]           dmem_rdata;
  logic [7:0]            tx_data;
  logic                  wr;
  logic                  tx_ready;

  modport master (
    input  start, pmem_size, dmem_size, pmem_rdata, dmem_rdata, tx_ready,
    output busy, done, pmem_addr, dmem_addr, tx_data, wr
  );

  modport slave (
    output start, pmem_size, dmem_size, pmem_rdata, dmem_rdata, tx_ready,
    input  busy, done, pmem_addr, dmem_addr, tx_data, wr
  );
endinterface

// File: rtl/img_sender_pacer.sv
// tx_byte_pacer: turns a held send request into single-cycle UART writes.
// sent pulses in the cycle wr is high; a write never follows another directly.
module tx_byte_pacer (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] byte_in,
  input  logic       tx_ready,
  output logic       sent,
  output logic       wr,
  output logic [7:0] tx_data
);
  logic       wr_r;
  logic [7:0] tx_data_r;
  logic       issue_s;

  // The cycle after a write is always skipped, so tx_ready is re-sampled fresh.
  always_comb begin
    issue_s = 1'b0;
    if (send && tx_ready && !wr_r) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Strobe and data registers; data holds until the next strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_r      <= 1'b0;
      tx_data_r <= 8'h00;
    end else begin
      wr_r <= issue_s;
      if (issue_s) begin
        tx_data_r <= byte_in;
      end
    end
  end

  assign wr      = wr_r;
  assign tx_data = tx_data_r;
  assign sent    = wr_r;
endmodule

// File: rtl/img_sender.sv
// img_sender: dumps pmem/dmem over the UART in boot-loader image format.
// Define IMG_SENDER_CKSUM_EN to append a modulo-256 checksum trailer byte.
module img_sender import common::*; #(
  parameter logic [ADDR_WIDTH-1:0] DMEM_GVAR_START = img_sender_pkg::DMEM_GVAR_START
) (
  input  logic         clk,
  input  logic         rst,
  img_sender_if.master bus
);
  import img_sender_pkg::*;

  img_send_state_t       state_r;
  img_send_state_t       state_nxt_s;
  img_send_state_t       after_meta_s;
  logic [1:0]            idx_r;
  logic [17:0]           word_r;
  logic [ADDR_WIDTH-1:0] psz_r;
  logic [ADDR_WIDTH-1:0] dsz_r;
  logic [ADDR_WIDTH-1:0] dend_r;
  logic [ADDR_WIDTH-1:0] pmem_addr_r;
  logic [ADDR_WIDTH-1:0] dmem_addr_r;
  logic [ADDR_WIDTH-1:0] dsz_cap_s;
  logic [15:0]           meta_p_s;
  logic [15:0]           meta_d_s;
  logic                  busy_r;
  logic                  done_r;
  logic                  send_s;
  logic [7:0]            byte_s;
  logic                  sent_s;
  logic                  last_s;
  logic                  finish_s;
  logic                  p_more_s;
  logic                  d_more_s;
  logic                  rd_wait_s;
  logic                  accept_s;
  logic [7:0]            tx_byte_s;
`ifdef IMG_SENDER_CKSUM_EN
  logic [7:0]            cksum_r;
`endif

  assign accept_s  = (state_r == IDLE) && bus.start;
  assign dsz_cap_s = bus.dmem_size & {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
  assign meta_p_s  = 16'(psz_r);
  assign meta_d_s  = 16'(dsz_r);
  assign last_s    = (idx_r == last_byte_idx(state_r));
  assign rd_wait_s = (state_r == PRD) || (state_r == DRD);
  // End of a section is detected by equality against the captured size.
  assign p_more_s  = ((pmem_addr_r + ADDR_ONE) != psz_r);
  assign d_more_s  = ((dmem_addr_r + ADDR_TWO) != dend_r);

  tx_byte_pacer u_pacer (
    .clk      (clk),
    .rst      (rst),
    .send     (send_s),
    .byte_in  (byte_s),
    .tx_ready (bus.tx_ready),
    .sent     (sent_s),
    .wr       (bus.wr),
    .tx_data  (tx_byte_s)
  );
  assign bus.tx_data = tx_byte_s;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s  = state_r;
    after_meta_s = FIN;
    if (psz_r != ADDR_ZERO) begin
      after_meta_s = PRD;
    end else if (dsz_r != ADDR_ZERO) begin
      after_meta_s = DRD;
    end else begin
      after_meta_s = FIN;
    end
    case (state_r)
      IDLE: state_nxt_s = bus.start ? HDR : IDLE;
      HDR:  state_nxt_s = (sent_s && last_s) ? META : HDR;
      META: state_nxt_s = (sent_s && last_s) ? after_meta_s : META;
      PRD:  state_nxt_s = (idx_r == 2'd1) ? PTX : PRD;
      PTX: begin
        if (sent_s && last_s) begin
          if (p_more_s) begin
            state_nxt_s = PRD;
          end else if (dsz_r != ADDR_ZERO) begin
            state_nxt_s = DRD;
          end else begin
            state_nxt_s = FIN;
          end
        end else begin
          state_nxt_s = PTX;
        end
      end
      DRD:  state_nxt_s = (idx_r == 2'd1) ? DTX : DRD;
      DTX: begin
        if (sent_s && last_s) begin
          state_nxt_s = d_more_s ? DRD : FIN;
        end else begin
          state_nxt_s = DTX;
        end
      end
`ifdef IMG_SENDER_CKSUM_EN
      FIN:  state_nxt_s = sent_s ? IDLE : FIN;
`else
      FIN:  state_nxt_s = IDLE;
`endif
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic: byte selection for the pacer and end-of-dump detection.
  always_comb begin
    send_s = 1'b0;
    byte_s = 8'h00;
    case (state_r)
      HDR: begin
        send_s = 1'b1;
        byte_s = (idx_r == 2'd0) ? IMG_MAGIC0 : IMG_MAGIC1;
      end
      META: begin
        send_s = 1'b1;
        case (idx_r)
          2'd0:    byte_s = meta_p_s[15:8];
          2'd1:    byte_s = meta_p_s[7:0];
          2'd2:    byte_s = meta_d_s[15:8];
          default: byte_s = meta_d_s[7:0];
        endcase
      end
      PTX: begin
        send_s = 1'b1;
        case (idx_r)
          2'd0:    byte_s = {6'b000000, word_r[17:16]};
          2'd1:    byte_s = word_r[15:8];
          default: byte_s = word_r[7:0];
        endcase
      end
      DTX: begin
        send_s = 1'b1;
        byte_s = (idx_r == 2'd0) ? word_r[15:8] : word_r[7:0];
      end
`ifdef IMG_SENDER_CKSUM_EN
      FIN: begin
        send_s = 1'b1;
        byte_s = cksum_r;
      end
`endif
      default: begin
        send_s = 1'b0;
        byte_s = 8'h00;
      end
    endcase
`ifdef IMG_SENDER_CKSUM_EN
    finish_s = (state_r == FIN) && sent_s;
`else
    finish_s = (state_r != FIN) && (state_nxt_s == FIN);
`endif
  end

  // Datapath: byte index, latched word, captured sizes, address counters, status.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_r       <= 2'd0;
      word_r      <= 18'd0;
      psz_r       <= ADDR_ZERO;
      dsz_r       <= ADDR_ZERO;
      dend_r      <= ADDR_ZERO;
      pmem_addr_r <= ADDR_ZERO;
      dmem_addr_r <= ADDR_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE) && !finish_s;
      done_r <= finish_s;
      if (state_nxt_s != state_r) begin
        idx_r <= 2'd0;
      end else if (sent_s || rd_wait_s) begin
        idx_r <= idx_r + 2'd1;
      end
      if (accept_s) begin
        psz_r  <= bus.pmem_size;
        dsz_r  <= dsz_cap_s;
        dend_r <= DMEM_GVAR_START + dsz_cap_s;
      end
      // Read data is taken in the second read cycle, one after the address.
      if (state_r == PRD && idx_r == 2'd1) begin
        word_r <= bus.pmem_rdata;
      end else if (state_r == DRD && idx_r == 2'd1) begin
        word_r <= {2'b00, bus.dmem_rdata};
      end
      if (state_r == META && state_nxt_s == PRD) begin
        pmem_addr_r <= ADDR_ZERO;
      end else if (state_r == PTX && sent_s && last_s) begin
        pmem_addr_r <= pmem_addr_r + ADDR_ONE;
      end
      if ((state_r == META || state_r == PTX) && state_nxt_s == DRD) begin
        dmem_addr_r <= DMEM_GVAR_START;
      end else if (state_r == DTX && sent_s && last_s) begin
        dmem_addr_r <= dmem_addr_r + ADDR_TWO;
      end
    end
  end

`ifdef IMG_SENDER_CKSUM_EN
  // Running sum of every byte after the magic header.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cksum_r <= 8'h00;
    end else if (accept_s) begin
      cksum_r <= 8'h00;
    end else if (sent_s && (state_r == META || state_r == PTX || state_r == DTX)) begin
      cksum_r <= cksum_r + tx_byte_s;
    end
  end
`endif

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pmem_addr = pmem_addr_r;
  assign bus.dmem_addr = dmem_addr_r;
endmodule

// File: tb/tb_img_sender.sv
// Self-checking bench for img_sender: memory and UART models plus a byte-stream reference.
`timescale 1ns/1ps
module tb_img_sender;
  import common::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  img_sender_if bus();
  img_sender dut (.clk(clk), .rst(rst), .bus(bus));

  int chk_total = 0;
  int chk_pass  = 0;

  logic [17:0] pmem_m [0:255];
  logic [15:0] dmem_m [0:511];
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];
  int          stall_len = 0;
  int          stall_cnt = 0;
  int          done_cnt  = 0;
  int          hs_viol   = 0;
  int          odd_addr  = 0;
  logic        prev_wr   = 1'b0;
  logic        rdy_m     = 1'b1;

  logic [7:0] vec_lit [0:15] = '{8'h55, 8'hAA, 8'h00, 8'h02, 8'h00, 8'h04, 8'h03, 8'h12,
                                 8'h34, 8'h00, 8'h00, 8'hFF, 8'hBE, 8'hEF, 8'h01, 8'h02};
  logic [7:0] ck_lit  [0:11] = '{8'h55, 8'hAA, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00,
                                 8'h01, 8'h00, 8'h01, 8'h05};

  assign bus.tx_ready = rdy_m;

  always @(posedge clk) begin
    bus.pmem_rdata <= pmem_m[bus.pmem_addr[7:0]];
    bus.dmem_rdata <= dmem_m[bus.dmem_addr[9:1]];
  end

  // UART model and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.wr === 1'b1) begin
      got_q.push_back(bus.tx_data);
      if (rdy_m !== 1'b1 || prev_wr !== 1'b0) hs_viol++;
      if (stall_len > 0) begin
        rdy_m = 1'b0;
        stall_cnt = stall_len;
      end
    end else if (stall_cnt > 0) begin
      stall_cnt--;
      if (stall_cnt == 0) rdy_m = 1'b1;
    end
    if (bus.done === 1'b1) done_cnt++;
    if (bus.dmem_addr[0] !== 1'b0) odd_addr++;
    prev_wr = bus.wr;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference image: header, sizes, pmem words as 3 bytes, dmem words as 2 bytes.
  task automatic build_exp(input int psz, input int dsz_raw);
    int dsz;
    logic [17:0] w;
    logic [15:0] d;
    logic [7:0] sum;
    exp_q.delete();
    dsz = dsz_raw - (dsz_raw % 2);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'((psz / 256) % 256));
    exp_q.push_back(8'(psz % 256));
    exp_q.push_back(8'((dsz / 256) % 256));
    exp_q.push_back(8'(dsz % 256));
    for (int i = 0; i < psz; i++) begin
      w = pmem_m[i];
      exp_q.push_back(8'(w / 65536));
      exp_q.push_back(8'((w / 256) % 256));
      exp_q.push_back(8'(w % 256));
    end
    for (int a = 256; a < 256 + dsz; a += 2) begin
      d = dmem_m[a / 2];
      exp_q.push_back(8'(d / 256));
      exp_q.push_back(8'(d % 256));
    end
`ifdef IMG_SENDER_CKSUM_EN
    sum = 8'h00;
    for (int i = 2; i < exp_q.size(); i++) sum = sum + exp_q[i];
    exp_q.push_back(sum);
`else
    sum = 8'h00;
`endif
  endtask

  function automatic int stream_diff(input int base);
    int n;
    n = got_q.size() - base;
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      if (got_q[base + i] !== exp_q[i]) return i;
    end
    if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
    return -1;
  endfunction

  task automatic run_dump(input int psz, input int dsz, input int budget, input int restart_at,
                          output int n_base, output int d_base, output bit timed_out);
    n_base = got_q.size();
    d_base = done_cnt;
    bus.start = 1'b1;
    bus.pmem_size = ADDR_WIDTH'(psz);
    bus.dmem_size = ADDR_WIDTH'(dsz);
    tick();
    bus.start = 1'b0;
    bus.pmem_size = ADDR_WIDTH'($urandom_range(0, 200));
    bus.dmem_size = ADDR_WIDTH'($urandom_range(0, 200));
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      tick();
      bus.start = (restart_at != 0 && c == restart_at) ? 1'b1 : 1'b0;
      if (done_cnt != d_base) begin
        timed_out = 1'b0;
        break;
      end
    end
    bus.start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", bus.busy); else chk_pass++;
    chk_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b required 0", bus.done); else chk_pass++;
    chk_total++; if (bus.wr !== 1'b0) $display("FAIL reset_wr: got %b required 0", bus.wr); else chk_pass++;
    chk_total++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h required 00", bus.tx_data); else chk_pass++;
    chk_total++; if (bus.pmem_addr !== '0) $display("FAIL reset_pmem_addr: got %h required 0", bus.pmem_addr); else chk_pass++;
    chk_total++; if (bus.dmem_addr !== '0) $display("FAIL reset_dmem_addr: got %h required 0", bus.dmem_addr); else chk_pass++;
  endtask

  task automatic test_empty();
    int nb, db, df;
    bit to;
    build_exp(0, 0);
    run_dump(0, 0, 500, 0, nb, db, to);
    chk_total++; if (to) $display("FAIL empty_timeout: got no done, required done"); else chk_pass++;
    df = stream_diff(nb);
    chk_total++; if (df != -1) $display("FAIL empty_stream: differs at byte %0d, got %0d bytes, required %0d", df, got_q.size() - nb, exp_q.size()); else chk_pass++;
    chk_total++; if (done_cnt - db != 1) $display("FAIL empty_done: got %0d pulses, required 1", done_cnt - db); else chk_pass++;
    chk_total++; if (bus.pmem_addr !== '0 || bus.dmem_addr !== '0) $display("FAIL empty_no_read: got addrs %h/%h, required 0/0", bus.pmem_addr, bus.dmem_addr); else chk_pass++;
  endtask

  task automatic test_vector(input int stall);
    int nb, db, df, vd;
    bit to;
    int v0;
    pmem_m[0] = 18'h3_1234;
    pmem_m[1] = 18'h0_00FF;
    dmem_m[9'h080] = 16'hBEEF;
    dmem_m[9'h081] = 16'h0102;
    build_exp(2, 4);
    stall_len = stall;
    v0 = hs_viol;
    run_dump(2, 4, 4000, 0, nb, db, to);
    stall_len = 0;
    chk_total++; if (to) $display("FAIL vector_timeout(stall %0d): got no done, required done", stall); else chk_pass++;
    df = stream_diff(nb);
    chk_total++; if (df != -1) $display("FAIL vector_stream(stall %0d): differs at byte %0d, got %0d bytes, required %0d", stall, df, got_q.size() - nb, exp_q.size()); else chk_pass++;
    vd = -1;
    for (int i = 0; i < 16; i++) begin
      if (vd == -1 && (nb + i >= got_q.size() || got_q[nb + i] !== vec_lit[i])) vd = i;
    end
    chk_total++; if (vd != -1) $display("FAIL vector_literal(stall %0d): first wrong byte %0d, required %h", stall, vd, vec_lit[vd]); else chk_pass++;
    chk_total++; if (done_cnt - db != 1) $display("FAIL vector_done(stall %0d): got %0d pulses, required 1", stall, done_cnt - db); else chk_pass++;
    chk_total++; if (hs_viol != v0) $display("FAIL vector_handshake(stall %0d): got %0d violations, required 0", stall, hs_viol - v0); else chk_pass++;
  endtask

  task automatic test_odd_dmem();
    int nb, db, df;
    bit to;
    build_exp(1, 5);
    run_dump(1, 5, 1000, 0, nb, db, to);
    chk_total++; if (to) $display("FAIL odd_timeout: got no done, required done"); else chk_pass++;
    df = stream_diff(nb);
    chk_total++; if (df != -1) $display("FAIL odd_stream: differs at byte %0d, got %0d bytes, required %0d", df, got_q.size() - nb, exp_q.size()); else chk_pass++;
    chk_total++; if (got_q.size() < nb + 6 || got_q[nb + 5] !== 8'h04) $display("FAIL odd_meta: got %0d bytes, required dmem size lo 04", got_q.size() - nb); else chk_pass++;
  endtask

  task automatic test_random();
    int nb, db, df, psz, dsz;
    bit to;
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < 256; i++) pmem_m[i] = 18'($urandom);
      for (int i = 0; i < 512; i++) dmem_m[i] = 16'($urandom);
      psz = $urandom_range(0, 6);
      dsz = $urandom_range(0, 11);
      build_exp(psz, dsz);
      run_dump(psz, dsz, 2000, 0, nb, db, to);
      chk_total++; if (to) $display("FAIL random_timeout(%0d/%0d): got no done, required done", psz, dsz); else chk_pass++;
      df = stream_diff(nb);
      chk_total++; if (df != -1) $display("FAIL random_stream(%0d/%0d): differs at byte %0d, got %0d bytes, required %0d", psz, dsz, df, got_q.size() - nb, exp_q.size()); else chk_pass++;
      chk_total++; if (done_cnt - db != 1) $display("FAIL random_done(%0d/%0d): got %0d pulses, required 1", psz, dsz, done_cnt - db); else chk_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int nb, db, df;
    bit to;
    build_exp(3, 6);
    run_dump(3, 6, 2000, 10, nb, db, to);
    chk_total++; if (to) $display("FAIL b2b_timeout: got no done, required done"); else chk_pass++;
    df = stream_diff(nb);
    chk_total++; if (df != -1) $display("FAIL b2b_ignore_start: differs at byte %0d, got %0d bytes, required %0d", df, got_q.size() - nb, exp_q.size()); else chk_pass++;
    chk_total++; if (done_cnt - db != 1) $display("FAIL b2b_done: got %0d pulses, required 1", done_cnt - db); else chk_pass++;
    build_exp(2, 2);
    run_dump(2, 2, 2000, 0, nb, db, to);
    df = stream_diff(nb);
    chk_total++; if (to || df != -1) $display("FAIL b2b_second: timeout %0d, differs at byte %0d, required full stream", to, df); else chk_pass++;
  endtask

  task automatic test_midreset();
    int nb, db, df;
    bit to, seen;
    nb = got_q.size();
    bus.start = 1'b1;
    bus.pmem_size = ADDR_WIDTH'(2);
    bus.dmem_size = ADDR_WIDTH'(4);
    tick();
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!seen) begin
        tick();
        if (got_q.size() - nb >= 7) seen = 1'b1;
      end
    end
    chk_total++; if (!seen || bus.busy !== 1'b1) $display("FAIL midrst_reach: got %0d bytes busy %b, required 7 bytes busy 1", got_q.size() - nb, bus.busy); else chk_pass++;
    rst = 1'b0;
    tick();
    chk_total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b required 0", bus.busy); else chk_pass++;
    chk_total++; if (bus.wr !== 1'b0) $display("FAIL midrst_wr: got %b required 0", bus.wr); else chk_pass++;
    chk_total++; if (bus.tx_data !== 8'h00 || bus.pmem_addr !== '0 || bus.dmem_addr !== '0) $display("FAIL midrst_outputs: got %h/%h/%h required 00/0/0", bus.tx_data, bus.pmem_addr, bus.dmem_addr); else chk_pass++;
    rst = 1'b1;
    tick();
    build_exp(2, 4);
    run_dump(2, 4, 2000, 0, nb, db, to);
    df = stream_diff(nb);
    chk_total++; if (to || df != -1) $display("FAIL midrst_restart: timeout %0d, differs at byte %0d, required full stream from 55 AA", to, df); else chk_pass++;
  endtask

  task automatic test_cksum();
    int nb, db, n, bad;
    bit to;
`ifdef IMG_SENDER_CKSUM_EN
    n = 12;
`else
    n = 11;
`endif
    pmem_m[0] = 18'h0_0001;
    dmem_m[9'h080] = 16'h0001;
    run_dump(1, 2, 1000, 0, nb, db, to);
    chk_total++; if (to || got_q.size() - nb != n) $display("FAIL cksum_len: got %0d bytes timeout %0d, required %0d", got_q.size() - nb, to, n); else chk_pass++;
    bad = -1;
    for (int i = 0; i < n; i++) begin
      if (bad == -1 && (nb + i >= got_q.size() || got_q[nb + i] !== ck_lit[i])) bad = i;
    end
    chk_total++; if (bad != -1) $display("FAIL cksum_bytes: first wrong byte %0d, required %h", bad, ck_lit[bad]); else chk_pass++;
  endtask

  task automatic test_protocol();
    chk_total++; if (hs_viol != 0) $display("FAIL handshake: got %0d violations, required 0", hs_viol); else chk_pass++;
    chk_total++; if (odd_addr != 0) $display("FAIL dmem_even: got %0d odd-address cycles, required 0", odd_addr); else chk_pass++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pmem_size = '0;
    bus.dmem_size = '0;
    for (int i = 0; i < 256; i++) pmem_m[i] = 18'($urandom);
    for (int i = 0; i < 512; i++) dmem_m[i] = 16'($urandom);
    test_reset();
    test_empty();
    test_vector(0);
    test_odd_dmem();
    test_vector(100);
    test_random();
    test_back_to_back();
    test_midreset();
    test_cksum();
    test_protocol();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end
endmodule
